// File: rtl/sort_stream_checker.sv
// sort_stream_checker: AXI-Stream sink verifying sort order, length and duplicate count per frame.
// Optional CHECKER_BACKPRESSURE_EN throttles ain_tready with a 16-bit LFSR while in RUN.
module sort_stream_checker #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_ELEMS  = 1024
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  sort_dir,
    input  logic [15:0]           exp_dups,
    input  logic [DATA_WIDTH-1:0] ain_tdata,
    input  logic                  ain_tvalid,
    output logic                  ain_tready,
    input  logic                  ain_tlast,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_ok,
    output logic [15:0]           elem_count,
    output logic [15:0]           dup_count,
    output logic [15:0]           order_errs,
    output logic [15:0]           first_err_idx,
    output logic                  len_err
);
    typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;
    state_t      state;
    logic        dir;
    logic [15:0] exp_q;
    logic [15:0] prev;
    logic [15:0] lo;
    logic [15:0] hi;
    logic        accept;
    logic        has_prev;
    logic        dup_p;
    logic        dup_h;
    logic        err_p;
    logic        err_h;
    logic [15:0] nxt_elem;
    logic [15:0] nxt_dup;
    logic [15:0] nxt_err;
    logic [15:0] nxt_first;
    logic [16:0] elem_sum;
    logic        len_hit;

    function automatic logic [15:0] sat(input logic [15:0] x, input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, x} + {15'd0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    assign lo       = ain_tdata[15:0];
    assign hi       = ain_tdata[31:16];
    assign busy     = state == RUN;
    assign frame_done = state == REPORT;
    assign accept   = busy && ain_tvalid && ain_tready;
    assign has_prev = elem_count != 16'd0;
    assign dup_p    = has_prev && prev == lo;
    assign dup_h    = lo == hi;
    assign err_p    = has_prev && (dir ? lo < prev : lo > prev);
    assign err_h    = dir ? hi < lo : hi > lo;
    assign nxt_elem = sat(elem_count, 2'd2);
    assign nxt_dup  = sat(dup_count, {1'b0, dup_p} + {1'b0, dup_h});
    assign nxt_err  = sat(order_errs, {1'b0, err_p} + {1'b0, err_h});
    assign nxt_first = first_err_idx != 16'hFFFF ? first_err_idx :
                       err_p ? elem_count : err_h ? elem_count + 16'd1 : 16'hFFFF;
    assign elem_sum = {1'b0, elem_count} + 17'd2;
    assign len_hit  = !ain_tlast && elem_sum >= 17'(MAX_ELEMS);

`ifdef CHECKER_BACKPRESSURE_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            lfsr <= 16'hACE1;
        else if (state == RUN)
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign ain_tready = state == RUN && lfsr[1:0] != 2'b00;
`else
    assign ain_tready = state == RUN;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            dir           <= 1'b1;
            exp_q         <= 16'd0;
            prev          <= 16'd0;
            elem_count    <= 16'd0;
            dup_count     <= 16'd0;
            order_errs    <= 16'd0;
            first_err_idx <= 16'hFFFF;
            frame_ok      <= 1'b0;
            len_err       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state         <= RUN;
                    dir           <= sort_dir;
                    exp_q         <= exp_dups;
                    elem_count    <= 16'd0;
                    dup_count     <= 16'd0;
                    order_errs    <= 16'd0;
                    first_err_idx <= 16'hFFFF;
                    frame_ok      <= 1'b0;
                    len_err       <= 1'b0;
                end
                RUN: if (accept) begin
                    prev          <= hi;
                    elem_count    <= nxt_elem;
                    dup_count     <= nxt_dup;
                    order_errs    <= nxt_err;
                    first_err_idx <= nxt_first;
                    // verdict is formed from the post-beat counts so it is valid alongside frame_done
                    if (ain_tlast || len_hit) begin
                        state    <= REPORT;
                        len_err  <= len_hit;
                        frame_ok <= nxt_err == 16'd0 && !len_hit && nxt_dup == exp_q;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sort_stream_checker.sv
// tb_sort_stream_checker: directed and randomized frames checked against an element-list reference model.
module tb_sort_stream_checker;
    localparam int MAX = 8;

    typedef struct {
        int cnt;
        int dups;
        int errs;
        int first;
        bit ok;
    } res_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        sort_dir = 1'b0;
    logic [15:0] exp_dups = 16'd0;
    logic [31:0] ain_tdata = 32'd0;
    logic        ain_tvalid = 1'b0;
    logic        ain_tready;
    logic        ain_tlast = 1'b0;
    logic        busy;
    logic        frame_done;
    logic        frame_ok;
    logic [15:0] elem_count;
    logic [15:0] dup_count;
    logic [15:0] order_errs;
    logic [15:0] first_err_idx;
    logic        len_err;

    int          n_asrt = 0;
    int          n_fail = 0;
    int          lowcyc = 0;
    bit          cur_dir;
    int          cur_exp;
    logic [15:0] el[$];
    logic [15:0] fe[$];
    res_t        pre;
    int          v;
    int          nb;
    bit          lf;
    bit          rdir;
    int          rexp;
    int          step;

    always #5 clk = ~clk;

    sort_stream_checker #(.DATA_WIDTH(32), .MAX_ELEMS(MAX)) dut (
        .clk(clk), .resetn(resetn), .start(start), .sort_dir(sort_dir), .exp_dups(exp_dups),
        .ain_tdata(ain_tdata), .ain_tvalid(ain_tvalid), .ain_tready(ain_tready), .ain_tlast(ain_tlast),
        .busy(busy), .frame_done(frame_done), .frame_ok(frame_ok), .elem_count(elem_count),
        .dup_count(dup_count), .order_errs(order_errs), .first_err_idx(first_err_idx), .len_err(len_err)
    );

    function automatic res_t model(input logic [15:0] e[$], input bit dir, input int exp, input bit lerr);
        res_t r;
        r.cnt = e.size();
        r.dups = 0;
        r.errs = 0;
        r.first = 'hFFFF;
        for (int i = 1; i < e.size(); i++) begin
            if (e[i] == e[i-1]) r.dups++;
            else if (dir ? e[i] < e[i-1] : e[i] > e[i-1]) begin
                r.errs++;
                if (r.first == 'hFFFF) r.first = i;
            end
        end
        r.ok = r.errs == 0 && !lerr && r.dups == exp;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset();
        chk("rst_tready", ain_tready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_ok", frame_ok, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_elem", elem_count, 0);
        chk("rst_dup", dup_count, 0);
        chk("rst_errs", order_errs, 0);
        chk("rst_first", first_err_idx, 32'hFFFF);
    endtask

    task automatic arm(input bit dir, input int ed);
        ain_tvalid = 1'b0;
        start = 1'b1;
        sort_dir = dir;
        exp_dups = 16'(ed);
        cur_dir = dir;
        cur_exp = ed;
        el.delete();
        @(negedge clk);
        start = 1'b0;
        chk("armed_busy", busy, 1);
    endtask

    task automatic beat(input logic [31:0] d, input bit last, input int gap);
        int n;
        n = 0;
        if (gap > 0) begin
            ain_tvalid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        chk("no_early_done", frame_done, 0);
        ain_tdata = d;
        ain_tlast = last;
        ain_tvalid = 1'b1;
        while (!ain_tready && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("tready_wait", ain_tready, 1);
        lowcyc += n;
        @(negedge clk);
        el.push_back(d[15:0]);
        el.push_back(d[31:16]);
    endtask

    task automatic check_frame(input bit lerr);
        res_t r;
        r = model(el, cur_dir, cur_exp, lerr);
        ain_tvalid = 1'b0;
        chk("frame_done", frame_done, 1);
        chk("elem_count", elem_count, r.cnt);
        chk("dup_count", dup_count, r.dups);
        chk("order_errs", order_errs, r.errs);
        chk("first_err_idx", first_err_idx, r.first);
        chk("frame_ok", frame_ok, r.ok);
        chk("len_err", len_err, lerr);
        chk("report_tready", ain_tready, 0);
        @(negedge clk);
        chk("done_pulse", frame_done, 0);
        chk("hold_ok", frame_ok, r.ok);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk_reset();
        resetn = 1'b1;
        @(negedge clk);
        chk_reset();

        // ascending 8-element frame, tvalid held across beats
        lowcyc = 0;
        arm(1, 1);
        beat(32'h0002_0001, 0, 0);
        beat(32'h0003_0003, 0, 0);
        beat(32'h0007_0005, 0, 0);
        beat(32'h0009_0008, 1, 0);
        chk("asc_ok_const", frame_ok, 1);
        check_frame(0);
`ifdef CHECKER_BACKPRESSURE_EN
        chk("tready_low_seen", lowcyc != 0, 1);
`endif

        arm(1, 0);
        beat(32'h0005_0004, 0, 0);
        beat(32'h0006_0003, 1, 0);
        chk("viol_first_const", first_err_idx, 2);
        check_frame(0);

        arm(0, 0);
        beat(32'h0009_0009, 0, 1);
        beat(32'h0001_0004, 1, 1);
        check_frame(0);

        // length error: 4 beats without tlast, then a 5th beat must stall
        arm(1, 0);
        beat(32'h0002_0001, 0, 0);
        beat(32'h0004_0003, 0, 0);
        beat(32'h0006_0005, 0, 0);
        beat(32'h0008_0007, 0, 0);
        check_frame(1);
        ain_tdata = 32'h000A_0009;
        ain_tvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("stall_tready", ain_tready, 0);
            @(negedge clk);
        end
        chk("stall_elem", elem_count, 8);
        ain_tvalid = 1'b0;

        // start during RUN is ignored
        arm(1, 3);
        beat(32'h0002_0001, 0, 0);
        ain_tvalid = 1'b0;
        start = 1'b1;
        sort_dir = 1'b0;
        exp_dups = 16'd7;
        @(negedge clk);
        start = 1'b0;
        chk("midstart_elem", elem_count, 2);
        chk("midstart_busy", busy, 1);
        beat(32'h0003_0002, 0, 1);
        beat(32'h0003_0003, 1, 0);
        check_frame(0);

        // reset mid-frame discards the partial frame
        arm(1, 0);
        beat(32'h0002_0001, 0, 0);
        beat(32'h0004_0003, 0, 0);
        ain_tvalid = 1'b0;
        resetn = 1'b0;
        #1;
        chk_reset();
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_done", frame_done, 0);
            chk("post_rst_busy", busy, 0);
            @(negedge clk);
        end

        for (int f = 0; f < 30; f++) begin
            rdir = 1'($urandom_range(0, 1));
            lf = $urandom_range(0, 4) == 0;
            nb = lf ? MAX / 2 : int'($urandom_range(1, 4));
            fe.delete();
            v = 1000;
            for (int k = 0; k < 2 * nb; k++) begin
                step = int'($urandom_range(0, 9));
                step = step < 3 ? 0 : step < 8 ? 1 : -2;
                v += rdir ? step : -step;
                fe.push_back(16'(v));
            end
            pre = model(fe, rdir, 0, 0);
            rexp = $urandom_range(0, 1) ? pre.dups : int'($urandom_range(0, 3));
            arm(rdir, rexp);
            for (int b = 0; b < nb; b++)
                beat({fe[2*b+1], fe[2*b]}, !lf && b == nb - 1, int'($urandom_range(0, 2)));
            check_frame(lf);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule

// File: doc/sort_stream_checker.md
Name: sort_stream_checker

Overview:
- AXI Stream sink at the output end of the sorter; consumes the sorted 32-bit stream.
- Each beat carries two 16-bit elements: element n in [15:0], element n+1 in [31:16].
- Per frame it checks ordering against sort_dir, counts elements and adjacent-equal duplicates, and compares the duplicate count with an expected value.
- Reports a per-frame verdict; used as the on-chip self-check and bench scoreboard for the sort path.

Parameters:
- DATA_WIDTH, 32, stream width; fixed to 2 x 16-bit elements.
- MAX_ELEMS, 1024, maximum elements per frame; reaching it without tlast is a length error.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; arms checker for next frame (ignored unless IDLE)
- sort_dir  in  1  1 = ascending, 0 = descending; sampled on accepted start
- exp_dups  in  16  expected duplicate count; sampled on accepted start
- ain_tdata  in  32  stream data
- ain_tvalid  in  1  stream valid
- ain_tready  out  1  stream ready
- ain_tlast  in  1  last beat of frame
- busy  out  1  high in RUN
- frame_done  out  1  one-cycle pulse when verdict outputs are valid
- frame_ok  out  1  no order error, no length error, dup_count == exp_dups
- elem_count  out  16  elements consumed in frame
- dup_count  out  16  adjacent-equal pairs in frame
- order_errs  out  16  adjacent out-of-order pairs in frame
- first_err_idx  out  16  index of first element violating order; 0xFFFF if none
- len_err  out  1  MAX_ELEMS reached without tlast

Behaviour:
- Reset: state IDLE; ain_tready, busy, frame_done, frame_ok, len_err = 0; all counts = 0; first_err_idx = 0xFFFF.
- FSM states: IDLE, RUN, REPORT.
- IDLE: ain_tready = 0. On start, go to RUN next cycle, latch sort_dir and exp_dups, clear counts, set first_err_idx = 0xFFFF, clear frame_ok and len_err. Verdict outputs hold their last values until then.
- RUN:
  - busy = 1; ain_tready = 1 (see Optional Feature).
  - A beat is accepted only when ain_tvalid && ain_tready.
  - Per accepted beat, with lo = [15:0] and hi = [31:16]:
    - Compare (prev, lo) only if elem_count > 0; always compare (lo, hi).
    - prev is the hi element of the previous beat.
  - Pair compare (a, b):
    - a == b: dup_count + 1.
    - Ascending and b < a, or descending and b > a: order_errs + 1. If first_err_idx is 0xFFFF, set it to the index of b.
  - A single beat may add up to 2 to each counter.
  - elem_count + 2 per beat. All counters update in the cycle after the handshake and saturate at 0xFFFF.
  - Beat with tlast: go to REPORT.
  - Beat without tlast that brings elem_count to >= MAX_ELEMS: set len_err = 1, go to REPORT.
  - ain_tready drops in the cycle after the final beat; no further beat is accepted in that frame.
- REPORT: exactly one cycle.
  - frame_done = 1; ain_tready = 0.
  - frame_ok = (order_errs == 0) && !len_err && (dup_count == exp_dups).
  - Next state IDLE.
- Latency: frame_done is asserted 1 cycle after the last-beat handshake.
- start while not IDLE is ignored.
- tvalid without start in IDLE: no accept; data stalls upstream.
- Reset mid-frame returns to IDLE immediately; the partial frame is discarded and no frame_done is produced.
- A single-beat frame (tlast on beat 0) performs only the (lo, hi) compare.

Optional Feature:
- Macro CHECKER_BACKPRESSURE_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16, 14, 13, 11; reset seed 0xACE1) advances every cycle in RUN.
  - In RUN, ain_tready = 1 only when lfsr[1:0] != 2'b00, stressing upstream hold of data under tvalid.
  - Verdict results are identical to the non-throttled case.
- Undefined: ain_tready = 1 for every RUN cycle; no LFSR logic is present.

Test Plan:
- Ascending 8-element frame.
  - Stimulus: start with sort_dir = 1, exp_dups = 1; beats 0x0002_0001, 0x0003_0003, 0x0007_0005, 0x0009_0008 (tlast).
  - Required: frame_done 1 cycle after beat 4; elem_count = 8, dup_count = 1, order_errs = 0, first_err_idx = 0xFFFF, frame_ok = 1.
- Order violation.
  - Stimulus: sort_dir = 1; beats 0x0005_0004, 0x0006_0003 (tlast).
  - Required: order_errs = 1, first_err_idx = 2, frame_ok = 0.
- Descending with duplicate mismatch.
  - Stimulus: sort_dir = 0, exp_dups = 0; beats 0x0009_0009, 0x0001_0004 (tlast).
  - Required: dup_count = 1, order_errs = 0, frame_ok = 0.
- Length error.
  - Stimulus: MAX_ELEMS = 8; 4 beats with tlast low.
  - Required: len_err = 1 and frame_done after beat 4; ain_tready = 0 afterwards; a 5th beat presented on tvalid is not accepted.
- Reset and start handling.
  - Stimulus: resetn pulsed low after 2 beats of a frame.
  - Required: IDLE, all outputs at reset values, no frame_done.
  - Stimulus: start pulsed during RUN.
  - Required: ignored; counters unaffected.
- With CHECKER_BACKPRESSURE_EN defined, first scenario repeated with tvalid held continuously.
  - Required: ain_tready shows low cycles; identical verdict (dup_count = 1, frame_ok = 1).
